// File: rtl/fir_pkg.sv
// Shared types and arithmetic for the FIR output stages.
// rshift_round is combinational and is reused by every stage that rescales samples.
package fir_pkg;

    localparam int W    = 16;
    localparam int FILL = 9;

    typedef logic signed [W-1:0] sample_t;

    typedef struct packed {
        logic    keep;
        sample_t dat;
    } stage_t;

    // Round-half-up arithmetic right shift; widened by one bit so the bias never overflows.
    function automatic sample_t rshift_round(input sample_t y, input int unsigned shift);
        logic signed [W:0] s;
        logic signed [W:0] bias;
        if (shift == 0) begin
            return y;
        end
        bias = (W+1)'(1) <<< (shift - 1);
        s    = $signed({y[W-1], y}) + bias;
        s    = s >>> shift;
        return sample_t'(s[W-1:0]);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO, one-cycle write-to-read; push at full accepted only with a same-cycle pop.
// pop_dat is the head entry (0 when empty); clr empties it and overrides push/pop.
module sample_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= push_dat;
    end

    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fir_out_decimator.sv
// FIR output stage: drop warm-up, decimate, round-shift, buffer. Latency 2 cycles y_in to out_valid.
// Backpressure via out_ready; when the FIFO is full with no pop the kept sample is dropped and overrun sticks.
module fir_out_decimator #(
    parameter  int W     = fir_pkg::W,
    parameter  int DECIM = 4,
    parameter  int SHIFT = 5,
    parameter  int FILL  = fir_pkg::FILL,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] y_in,
    input  logic                clr,
    output logic signed [W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic [LW-1:0]       level
);
    import fir_pkg::*;

    localparam int WCW = (FILL > 0) ? $clog2(FILL + 1) : 1;
    localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [PW-1:0]  phase_q, phase_d;
    stage_t         stage_q, stage_d;
    logic           overrun_q, overrun_d;
    logic           warm;
    logic           keep;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W-1:0]   head_dat;

    // Warm-up saturates at FILL; the phase only starts counting once it has.
    always_comb begin
        warm    = (wcnt_q == WCW'(FILL));
        keep    = warm && (phase_q == '0);
        wcnt_d  = wcnt_q;
        phase_d = phase_q;
        stage_d = stage_q;
        if (clr) begin
            wcnt_d  = '0;
            phase_d = '0;
            stage_d = '0;
        end else begin
            if (!warm) begin
                wcnt_d = wcnt_q + WCW'(1);
            end else if (phase_q == PW'(DECIM - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
            stage_d.keep = keep;
            stage_d.dat  = rshift_round(y_in, SHIFT);
        end
    end

    always_comb begin
        pop       = out_valid && out_ready;
        overrun_d = overrun_q;
        if (clr) begin
            overrun_d = 1'b0;
        end else if (stage_q.keep && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q    <= '0;
            phase_q   <= '0;
            stage_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            phase_q   <= phase_d;
            stage_q   <= stage_d;
            overrun_q <= overrun_d;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .push     (stage_q.keep),
        .push_dat (stage_q.dat),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_dat;
    assign overrun   = overrun_q;

endmodule
